dma_read_master: RTL and testbench
==================================

// Module: dma_read_master
// PURPOSE
//  Read-side master of the DMA. Consumes start address, byte length and GO from the DMA
//  control slave and issues pipelined Avalon-MM word reads. Returned data is pushed into
//  the read/write FIFO drained by the write master.
//  Flow control: an outstanding-read counter plus the FIFO almost-full flag.
// PARAMETERS
//  DATA_W       32  read data / FIFO word width (bits); byte length counts DATA_W/8 per word
//  MAX_PENDING  8   max reads issued but not yet returned (1..15)
// PORTS
//  iClk              in   1       clock
//  iReset_n          in   1       async active-low reset
//  iStart            in   1       GO level from control slave; rising edge starts a transfer
//  iStartaddress     in   32      byte start address, sampled on start
//  iLength           in   32      byte count, sampled on start
//  oAddress          out  32      Avalon-MM read address (byte)
//  oRead             out  1       Avalon-MM read request
//  iWaitrequest      in   1       slave stall; hold oAddress/oRead while high
//  iReaddata         in   DATA_W  read data
//  iReaddatavalid    in   1       read data valid (pipelined, in order)
//  oFifo_wrreq       out  1       FIFO write strobe
//  oFifo_data        out  DATA_W  FIFO write data
//  iFifo_almostfull  in   1       FIFO free space < MAX_PENDING words
//  oBusy             out  1       transfer in progress
//  oDone             out  1       one-cycle pulse when last word is written to FIFO
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Reset mid-transfer aborts it. Outstanding
//   reads are not tracked after reset; late readdatavalid is ignored in IDLE.
//  Start detect: registered iStart; start = iStart & ~iStart_q, honoured only in IDLE.
//   Edges in any other state are ignored.
//  Start action: addr<=iStartaddress, words_left<=iLength>>log2(DATA_W/8)
//   (remainder bytes dropped), words_rcv<=same count.
//  FSM IDLE -> ISSUE on start. If the word count is 0, go straight to DONE.
//   ISSUE -> DRAIN when the last read is accepted (oRead & ~iWaitrequest & words_left==1).
//   DRAIN -> DONE when words_rcv reaches 0.
//   DONE -> IDLE after 1 cycle. oDone=1 exactly in DONE.
//  oBusy=1 in ISSUE/DRAIN/DONE.
//  Issue: oRead=1 in ISSUE when pending<MAX_PENDING and ~iFifo_almostfull.
//   Once asserted, oRead/oAddress hold until accepted, even if almostfull rises.
//   Accept = oRead & ~iWaitrequest: addr+=DATA_W/8 (wraps mod 2^32), words_left-=1.
//   oRead drops the cycle after the last accept.
//  pending: +1 on accept, -1 on iReaddatavalid; both in one cycle -> unchanged.
//   Never exceeds MAX_PENDING.
//  Return: oFifo_wrreq=iReaddatavalid registered (1-cycle latency), oFifo_data=iReaddata
//   registered. Each valid word decrements words_rcv.
//   Readdatavalid in IDLE is dropped (no wrreq).
//  Last-word timing: oDone is asserted the cycle after the last oFifo_wrreq.
//   Minimum 1-word transfer: start edge -> oRead next cycle.
//  Length 0: oBusy and oDone for one DONE cycle each, no bus reads, no FIFO writes.
// CONFIGURATION
//  RM_ALIGN_CHECK_EN defined: adds output oError (1 bit, reset 0).
//   Start with iStartaddress[1:0]!=0 or iLength[1:0]!=0 issues no reads and goes to DONE.
//   oError=1 together with oDone for that single cycle.
//  RM_ALIGN_CHECK_EN undefined: no oError port. Address low bits are forced to 0 on start;
//   the length remainder is dropped as above.
// TESTING
//  1 addr=0x1000 len=16, waitreq=0, data valid 2 cycles after accept -> reads at
//    0x1000/4/8/C; 4 wrreq in order; oDone 1 pulse.
//  2 len=40 (10 words), MAX_PENDING=8, readdatavalid withheld -> exactly 8 accepts, then oRead=0
//    until data returns.
//  3 iFifo_almostfull=1 at start -> no oRead; release -> reads begin the next cycle.
//    Raise almostfull while oRead is stalled by waitrequest -> oRead/oAddress held until accept.
//  4 len=0 -> oBusy 1 cycle, oDone 1 cycle, zero oRead/wrreq.
//    Re-raising iStart while busy -> ignored.
//  5 iReset_n low during DRAIN -> outputs 0 immediately. Stray readdatavalid afterwards -> no wrreq.
//    New start works.
//  6 addr=0xFFFFFFF8 len=16 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
//    With RM_ALIGN_CHECK_EN: addr=0x1002 -> oError and oDone same cycle, no reads.

Source files
------------

// File: rtl/dma_read_master.sv
// DMA read master: issues pipelined Avalon-MM word reads and pushes the returned data into the FIFO.
// Optional build macro RM_ALIGN_CHECK_EN adds oError and rejects unaligned starts.
module dma_read_master #(
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic [31:0]       iStartaddress,
  input  logic [31:0]       iLength,
  output logic [31:0]       oAddress,
  output logic              oRead,
  input  logic              iWaitrequest,
  input  logic [DATA_W-1:0] iReaddata,
  input  logic              iReaddatavalid,
  output logic              oFifo_wrreq,
  output logic [DATA_W-1:0] oFifo_data,
  input  logic              iFifo_almostfull,
  output logic              oBusy,
  output logic              oDone,
`ifdef RM_ALIGN_CHECK_EN
  output logic              oError,
`endif
  output logic [1:0]        oDbg_state
);

  localparam int          BYTES     = DATA_W / 8;
  localparam int          SHIFT     = $clog2(BYTES);
  localparam logic [31:0] ADDR_STEP = 32'(BYTES);
  localparam logic [3:0]  PEND_MAX  = 4'(MAX_PENDING);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_start_q;
  logic              r_hold;
  logic              r_wrreq;
  logic [31:0]       r_addr;
  logic [31:0]       r_words_left;
  logic [31:0]       r_words_rcv;
  logic [3:0]        r_pending;
  logic [DATA_W-1:0] r_data;

  logic              w_start;
  logic              w_accept;
  logic              w_ret;
  logic              w_bad;
  logic [31:0]       w_base;
  logic [31:0]       w_count;

`ifdef RM_ALIGN_CHECK_EN
  assign w_bad  = (|iStartaddress[1:0]) | (|iLength[1:0]);
  assign w_base = iStartaddress;
`else
  assign w_bad  = 1'b0;
  assign w_base = iStartaddress & ~(ADDR_STEP - 32'd1);
`endif

  assign w_count = w_bad ? 32'd0 : (iLength >> SHIFT);
  assign w_start = iStart & ~r_start_q & (r_state == S_IDLE);

  // Handshake: a read transfers on a cycle where oRead=1 and iWaitrequest=0; while stalled,
  // oRead and oAddress are held (r_hold) regardless of the FIFO almost-full flag.
  assign w_accept = oRead & ~iWaitrequest;

  // Returned words are only counted while a transfer is live; late data after reset is dropped.
  assign w_ret = iReaddatavalid & ((r_state == S_ISSUE) | (r_state == S_DRAIN)) &
                 (r_words_rcv != 32'd0);

  always_comb begin
    w_state_nxt = r_state;
    oRead       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = (w_count == 32'd0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        oRead = r_hold | ((r_pending < PEND_MAX) & ~iFifo_almostfull);
        if (oRead & ~iWaitrequest & (r_words_left == 32'd1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_words_rcv == 32'd0) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state      <= S_IDLE;
      r_start_q    <= 1'b0;
      r_hold       <= 1'b0;
      r_wrreq      <= 1'b0;
      r_addr       <= 32'd0;
      r_words_left <= 32'd0;
      r_words_rcv  <= 32'd0;
      r_pending    <= 4'd0;
      r_data       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= iStart;
      r_hold    <= oRead & iWaitrequest;
      r_wrreq   <= w_ret;
      if (w_ret) r_data <= iReaddata;
      case ({w_accept, w_ret})
        2'b10:   r_pending <= r_pending + 4'd1;
        2'b01:   r_pending <= r_pending - 4'd1;
        default: r_pending <= r_pending;
      endcase
      if (w_start) begin
        r_addr       <= w_base;
        r_words_left <= w_count;
        r_words_rcv  <= w_count;
      end else begin
        if (w_accept) begin
          r_addr       <= r_addr + ADDR_STEP;
          r_words_left <= r_words_left - 32'd1;
        end
        if (w_ret) r_words_rcv <= r_words_rcv - 32'd1;
      end
    end
  end

`ifdef RM_ALIGN_CHECK_EN
  logic r_error;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)    r_error <= 1'b0;
    else if (w_start) r_error <= w_bad;
  end

  assign oError = r_error & (r_state == S_DONE);
`endif

  assign oAddress    = r_addr;
  assign oFifo_wrreq = r_wrreq;
  assign oFifo_data  = r_data;
  assign oBusy       = (r_state != S_IDLE);
  assign oDone       = (r_state == S_DONE);
  assign oDbg_state  = r_state;

endmodule

// File: tb/tb_dma_read_master.sv
// Bench for dma_read_master: behavioural Avalon slave plus a transfer-level reference model.
module tb_dma_read_master;

  localparam int DATA_W      = 32;
  localparam int MAX_PENDING = 8;
  localparam int BIG         = 32'h3fff_ffff;

  logic              clk = 1'b0;
  logic              iReset_n = 1'b0;
  logic              iStart = 1'b0;
  logic [31:0]       iStartaddress = '0;
  logic [31:0]       iLength = '0;
  logic [31:0]       oAddress;
  logic              oRead;
  logic              iWaitrequest = 1'b0;
  logic [DATA_W-1:0] iReaddata = '0;
  logic              iReaddatavalid = 1'b0;
  logic              oFifo_wrreq;
  logic [DATA_W-1:0] oFifo_data;
  logic              iFifo_almostfull = 1'b0;
  logic              oBusy;
  logic              oDone;
  logic [1:0]        oDbg_state;
`ifdef RM_ALIGN_CHECK_EN
  logic              oError;
`endif

  dma_read_master #(.DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)) dut (
    .iClk(clk), .iReset_n(iReset_n), .iStart(iStart),
    .iStartaddress(iStartaddress), .iLength(iLength),
    .oAddress(oAddress), .oRead(oRead), .iWaitrequest(iWaitrequest),
    .iReaddata(iReaddata), .iReaddatavalid(iReaddatavalid),
    .oFifo_wrreq(oFifo_wrreq), .oFifo_data(oFifo_data),
    .iFifo_almostfull(iFifo_almostfull), .oBusy(oBusy), .oDone(oDone),
`ifdef RM_ALIGN_CHECK_EN
    .oError(oError),
`endif
    .oDbg_state(oDbg_state)
  );

  always #5 clk = ~clk;

  // stimulus controls
  int wr_mode = 0;   // 0 never stall, 1 random stall, 2 always stall
  int af_mode = 0;   // 0 low, 1 high, 2 random
  int lat_fix = 2;
  bit lat_rand = 0;
  bit hold_rsp = 0;
  bit stray = 0;

  // slave and scoreboard state
  logic [DATA_W-1:0] rsp_q[$];
  int                due_q[$];
  logic [31:0]       exp_addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int  cyc = 0;
  int  busy_from = BIG;
  int  exp_done_cyc = BIG;
  bit  exp_err = 0;
  bit  xfer_done = 1;
  bit  prev_stall = 0;
  logic [31:0] prev_addr = '0;
  int  outst = 0;
  int  acc_cnt = 0;
  int  wr_cnt = 0;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic monitor();
    if (!iReset_n) begin
      check("rst_read", 32'(oRead), 0);
      check("rst_busy", 32'(oBusy), 0);
      check("rst_wrreq", 32'(oFifo_wrreq), 0);
      check("rst_done", 32'(oDone), 0);
      rsp_q.delete(); due_q.delete(); exp_addr_q.delete(); exp_q.delete();
      busy_from = BIG; exp_done_cyc = BIG; exp_err = 0; xfer_done = 1;
      prev_stall = 0; outst = 0;
      return;
    end
    if (prev_stall) begin
      check("hold_read", 32'(oRead), 1);
      check("hold_addr", oAddress, prev_addr);
    end
    prev_stall = oRead && iWaitrequest;
    prev_addr  = oAddress;
    if (oRead && !iWaitrequest) begin
      acc_cnt++;
      outst++;
      check("read_expected", 32'(exp_addr_q.size() != 0), 1);
      if (exp_addr_q.size() != 0) check("read_addr", oAddress, exp_addr_q.pop_front());
      rsp_q.push_back(mem_word(oAddress));
      due_q.push_back(cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_fix));
    end
    if (iReaddatavalid && outst > 0) outst--;
    check("pending_bound", 32'(outst <= MAX_PENDING), 1);
    if (oFifo_wrreq) begin
      check("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("wr_data", oFifo_data, exp_q.pop_front());
        wr_cnt++;
        if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
      end
    end
    check("done", 32'(oDone), 32'(cyc == exp_done_cyc));
    check("busy", 32'(oBusy), 32'(cyc >= busy_from && cyc <= exp_done_cyc));
`ifdef RM_ALIGN_CHECK_EN
    check("error", 32'(oError), 32'(cyc == exp_done_cyc && exp_err));
`endif
    if (cyc == exp_done_cyc) begin
      busy_from = BIG; exp_done_cyc = BIG; xfer_done = 1;
    end
  endtask

  // one clock: slave drives at posedge+1, everything is observed on the falling edge
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    case (wr_mode)
      0:       iWaitrequest = 1'b0;
      1:       iWaitrequest = ($urandom_range(0, 2) == 0);
      default: iWaitrequest = 1'b1;
    endcase
    case (af_mode)
      0:       iFifo_almostfull = 1'b0;
      1:       iFifo_almostfull = 1'b1;
      default: iFifo_almostfull = ($urandom_range(0, 4) == 0);
    endcase
    if (stray) begin
      iReaddatavalid = 1'b1; iReaddata = $urandom; stray = 0;
    end else if (!hold_rsp && due_q.size() != 0 && due_q[0] <= cyc) begin
      iReaddatavalid = 1'b1; iReaddata = rsp_q.pop_front(); void'(due_q.pop_front());
    end else begin
      iReaddatavalid = 1'b0; iReaddata = $urandom;
    end
    @(negedge clk);
    monitor();
  endtask

  // reference: n = len / bytes-per-word words from the word-aligned base, wrapping mod 2^32
  task automatic start_xfer(input logic [31:0] addr, input logic [31:0] len);
    logic [31:0] base;
    int n;
    base = addr & ~32'd3;
    n = int'(len / 4);
    exp_err = 0;
`ifdef RM_ALIGN_CHECK_EN
    if (addr % 4 != 0 || len % 4 != 0) begin
      exp_err = 1; n = 0;
    end
`endif
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(base + 32'(4 * i));
      exp_q.push_back(mem_word(base + 32'(4 * i)));
    end
    busy_from = cyc + 1;
    exp_done_cyc = (n == 0) ? cyc + 1 : BIG;
    xfer_done = 0;
    iStartaddress = addr;
    iLength = len;
    iStart = 1'b1;
    cycle();
    iStart = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && !xfer_done; k++) cycle();
    check("xfer_timeout", 32'(xfer_done), 1);
    cycle();
    cycle();
  endtask

  int a0, w0;

  initial begin
    repeat (3) cycle();
    iReset_n = 1'b1;
    cycle();

    // basic 4-word read, fixed latency 2
    a0 = acc_cnt; w0 = wr_cnt;
    start_xfer(32'h0000_1000, 32'd16);
    check("start_latency", 32'(oRead), 1);
    check("first_addr", oAddress, 32'h0000_1000);
    wait_done();
    check("t1_reads", 32'(acc_cnt - a0), 4);
    check("t1_writes", 32'(wr_cnt - w0), 4);

    // outstanding limit with data withheld
    lat_fix = 1; hold_rsp = 1; a0 = acc_cnt;
    start_xfer(32'h0000_2000, 32'd40);
    repeat (20) cycle();
    check("pend_accepts", 32'(acc_cnt - a0), 8);
    check("pend_read_off", 32'(oRead), 0);
    hold_rsp = 0;
    wait_done();
    check("t2_reads", 32'(acc_cnt - a0), 10);

    // almost-full gating and hold under stall
    af_mode = 1; cycle(); a0 = acc_cnt;
    start_xfer(32'h0000_3000, 32'd32);
    repeat (5) cycle();
    check("af_no_reads", 32'(acc_cnt - a0), 0);
    check("af_read_off", 32'(oRead), 0);
    wr_mode = 2; af_mode = 0;
    cycle();
    check("af_release", 32'(oRead), 1);
    check("stall_addr", oAddress, 32'h0000_3000);
    af_mode = 1;
    repeat (3) cycle();
    check("af_hold_read", 32'(oRead), 1);
    check("af_hold_addr", oAddress, 32'h0000_3000);
    wr_mode = 0; a0 = acc_cnt;
    cycle();
    check("stall_accept", 32'(acc_cnt - a0), 1);
    cycle();
    check("af_block", 32'(oRead), 0);
    af_mode = 0;
    wait_done();

    // zero length, then a start edge while busy
    a0 = acc_cnt; w0 = wr_cnt;
    start_xfer(32'h0000_4000, 32'd0);
    wait_done();
    check("len0_reads", 32'(acc_cnt - a0), 0);
    check("len0_writes", 32'(wr_cnt - w0), 0);
    wr_mode = 1; lat_rand = 1;
    start_xfer(32'h0000_4100, 32'd24);
    repeat (3) cycle();
    iStart = 1'b1; cycle(); iStart = 1'b0;
    wait_done();
    wr_mode = 0; lat_rand = 0;

    // reset while draining, stray data afterwards, then a fresh transfer
    hold_rsp = 1; a0 = acc_cnt;
    start_xfer(32'h0000_5000, 32'd16);
    for (int k = 0; k < 100 && acc_cnt < a0 + 4; k++) cycle();
    cycle();
    check("drain_busy", 32'(oBusy), 1);
    iReset_n = 1'b0;
    #1;
    check("rst_now_read", 32'(oRead), 0);
    check("rst_now_busy", 32'(oBusy), 0);
    check("rst_now_addr", oAddress, 0);
    cycle(); cycle();
    iReset_n = 1'b1; hold_rsp = 0; stray = 1;
    cycle(); cycle();
    check("stray_wrreq", 32'(oFifo_wrreq), 0);
    start_xfer(32'h0000_5100, 32'd8);
    wait_done();

    // address wrap
    start_xfer(32'hFFFF_FFF8, 32'd16);
    wait_done();
`ifdef RM_ALIGN_CHECK_EN
    a0 = acc_cnt;
    start_xfer(32'h0000_1002, 32'd16);
    wait_done();
    check("unaligned_reads", 32'(acc_cnt - a0), 0);
`endif

    // randomized transfers
    wr_mode = 1; af_mode = 2; lat_rand = 1;
    for (int t = 0; t < 25; t++) begin
      logic [31:0] ra, rl;
      ra = $urandom;
      rl = $urandom_range(0, 64);
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) rl[1:0] = 2'b00;
      start_xfer(ra, rl);
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
